// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit core: sequencer states, branch types,
// condition codes and PSR flag bit positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_FETCH_WAIT = 3'd1,
    ST_DECODE     = 3'd2,
    ST_EXECUTE    = 3'd3,
    ST_PC_UPDATE  = 3'd4,
    ST_HALT       = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_BCOND = 2'b01,
    BR_JCOND = 2'b10,
    BR_JAL   = 2'b11
  } br_type_t;

  typedef enum logic [3:0] {
    CC_EQ = 4'b0000,
    CC_NE = 4'b0001,
    CC_CS = 4'b0010,
    CC_CC = 4'b0011,
    CC_HI = 4'b0100,
    CC_LS = 4'b0101,
    CC_GT = 4'b0110,
    CC_LE = 4'b0111,
    CC_FS = 4'b1000,
    CC_FC = 4'b1001,
    CC_LO = 4'b1010,
    CC_HS = 4'b1011,
    CC_LT = 4'b1100,
    CC_GE = 4'b1101,
    CC_UC = 4'b1110,
    CC_NV = 4'b1111
  } cond_t;

  // psr_flags is packed {N,Z,F,L,C}
  localparam int unsigned PSR_N = 4;
  localparam int unsigned PSR_Z = 3;
  localparam int unsigned PSR_F = 2;
  localparam int unsigned PSR_L = 1;
  localparam int unsigned PSR_C = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluation: cond field against PSR flags -> take.
// Shared by the sequencer (branches/jumps) and the execute unit (Scond).
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] psr_flags,
  output logic       take
);

  logic n, z, f, l, c;

  always_comb begin
    n = psr_flags[PSR_N];
    z = psr_flags[PSR_Z];
    f = psr_flags[PSR_F];
    l = psr_flags[PSR_L];
    c = psr_flags[PSR_C];
    take = 1'b0;
    case (cond_t'(cond))
      CC_EQ:   take = z;
      CC_NE:   take = ~z;
      CC_CS:   take = c;
      CC_CC:   take = ~c;
      CC_HI:   take = l;
      CC_LS:   take = ~l;
      CC_GT:   take = n;
      CC_LE:   take = ~n;
      CC_FS:   take = f;
      CC_FC:   take = ~f;
      CC_LO:   take = ~l & ~z;
      CC_HS:   take = l | z;
      CC_LT:   take = ~n & ~z;
      CC_GE:   take = n | z;
      CC_UC:   take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute controller: owns PC and IR, runs the fetch
// handshake, resolves branches and drives the PC-update datapath.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             instr_req,
  output logic [WIDTH-1:0] instr_addr,
  input  logic             instr_ack,
  input  logic [WIDTH-1:0] instr_in,
  output logic [WIDTH-1:0] ir,
  input  logic [1:0]       br_type,
  input  logic [3:0]       cond,
  input  logic [4:0]       psr_flags,
  input  logic             exec_done,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic             jumpEN,
  output logic             jalEN,
  input  logic [WIDTH-1:0] pc_next,
  input  logic [WIDTH-1:0] rlink,
  output logic             link_we,
  output logic [WIDTH-1:0] link_data,
  output logic [2:0]       state_dbg
);

  state_t state, state_nx;
  logic   fetching, ir_load, pc_load, exec_capture;
  logic   take, jump_r, jal_r, link_r;

  cond_eval u_cond_eval (
    .cond      (cond),
    .psr_flags (psr_flags),
    .take      (take)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      jump_r    <= 1'b0;
      jal_r     <= 1'b0;
      link_r    <= 1'b0;
      link_data <= '0;
    end else begin
      state <= state_nx;
      if (ir_load)      ir <= instr_in;
      if (pc_load)      pc <= pc_next;
      if (exec_capture) begin
        jump_r <= (br_type == BR_BCOND) & take;
        jal_r  <= (br_type == BR_JAL) | ((br_type == BR_JCOND) & take);
        link_r <= (br_type == BR_JAL);
      end
      if (link_we) link_data <= rlink;
    end
  end

  always_comb begin
    state_nx     = ST_FETCH;
    fetching     = 1'b0;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    exec_capture = 1'b0;
    jumpEN       = 1'b0;
    jalEN        = 1'b0;
    link_we      = 1'b0;
    case (state)
      ST_FETCH: begin
        fetching = 1'b1;
        if (instr_ack) begin
          ir_load  = 1'b1;
          state_nx = ST_DECODE;
        end else begin
          state_nx = ST_FETCH_WAIT;
        end
      end
      ST_FETCH_WAIT: begin
        fetching = 1'b1;
        if (instr_ack) begin
          ir_load  = 1'b1;
          state_nx = ST_DECODE;
        end else begin
          state_nx = ST_FETCH_WAIT;
        end
      end
      ST_DECODE: begin
        // With both enables low the datapath returns pc+1, so WAIT still advances the PC
        if (halt_req) begin
          pc_load  = 1'b1;
          state_nx = ST_HALT;
        end else begin
          state_nx = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (exec_done) begin
          exec_capture = 1'b1;
          state_nx     = ST_PC_UPDATE;
        end else begin
          state_nx = ST_EXECUTE;
        end
      end
      ST_PC_UPDATE: begin
        jalEN    = jal_r;
        jumpEN   = jump_r & ~jal_r;
        link_we  = link_r;
        pc_load  = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_HALT: begin
        state_nx = resume ? ST_FETCH : ST_HALT;
      end
      default: state_nx = ST_FETCH;
    endcase
  end

  // Gated with reset_n so an asserted reset drops the request without waiting for a clock
  assign instr_req  = fetching & reset_n;
  assign instr_addr = pc;
  assign state_dbg  = state;

endmodule
